// File: rtl/memcontrol_pkg.sv
// Shared types and default widths for the memory controller arbiter.
package memcontrol_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ_REQ  = 3'd1,
    WRITE_REQ = 3'd2,
    FETCH_REQ = 3'd3,
    WAIT      = 3'd4,
    DONE      = 3'd5
  } state_t;

  typedef enum logic {
    SRC_DATA  = 1'b0,
    SRC_INSTR = 1'b1
  } src_t;

  function automatic logic is_req(input state_t s);
    return (s == READ_REQ) || (s == WRITE_REQ) || (s == FETCH_REQ);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating WAIT-cycle counter; flags the first WAIT cycle and the timeout limit.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic first,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign first   = (cnt_q == '0);
  assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/memcontrol_arb.sv
// Arbitrates the data and instruction-fetch ports onto one bus master with
// a request/wait/done handshake and a WAIT timeout abort.
module memcontrol_arb
  import memcontrol_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address_in,
  input  logic [ADDR_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   data_in_CPU,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic                instr_en,
  input  logic [DATA_W-1:0]   data_in_BUS,
  input  logic                bus_full,
  output logic [ADDR_W-1:0]   address_out,
  output logic [DATA_W-1:0]   data_out_BUS,
  output logic [DATA_W/8-1:0] sel_out,
  output logic                bus_read,
  output logic                bus_write,
  output logic [DATA_W-1:0]   data_out_CPU,
  output logic [DATA_W-1:0]   data_out_INSTR,
  output logic                data_ack,
  output logic                instr_ack,
  output logic                bus_err,
  output state_t              state
);

  localparam int SEL_W = DATA_W / 8;

  state_t            state_q, state_d;
  src_t              src_q, src_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rd_cpu_q, rd_cpu_d;
  logic [DATA_W-1:0] rd_instr_q, rd_instr_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;
  logic              data_ack_q, data_ack_d;
  logic              instr_ack_q, instr_ack_d;
  logic              bus_err_q, bus_err_d;

  logic wait_first, wait_expired;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (is_req(state_q)),
    .en      (state_q == WAIT),
    .first   (wait_first),
    .expired (wait_expired)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rd_cpu_d    = rd_cpu_q;
    rd_instr_d  = rd_instr_q;
    bus_read_d  = 1'b0;
    bus_write_d = 1'b0;
    data_ack_d  = 1'b0;
    instr_ack_d = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Fixed priority: a simultaneous read is dropped in favour of the write.
        if (memWrite) begin
          state_d     = WRITE_REQ;
          src_d       = SRC_DATA;
          wr_d        = 1'b1;
          addr_d      = address_in;
          wdata_d     = data_in_CPU;
          sel_d       = byte_en;
          bus_write_d = 1'b1;
        end else if (memRead) begin
          state_d    = READ_REQ;
          src_d      = SRC_DATA;
          wr_d       = 1'b0;
          addr_d     = address_in;
          wdata_d    = data_in_CPU;
          sel_d      = '1;
          bus_read_d = 1'b1;
        end else if (instr_en) begin
          state_d    = FETCH_REQ;
          src_d      = SRC_INSTR;
          wr_d       = 1'b0;
          addr_d     = pc_in;
          wdata_d    = data_in_CPU;
          sel_d      = '1;
          bus_read_d = 1'b1;
        end
      end
      READ_REQ, WRITE_REQ, FETCH_REQ: state_d = WAIT;
      WAIT: begin
        // The first WAIT cycle never completes; completion outranks timeout.
        if (!wait_first && !bus_full) begin
          state_d = DONE;
          if (src_q == SRC_DATA) begin
            data_ack_d = 1'b1;
            if (!wr_q) rd_cpu_d = data_in_BUS;
          end else begin
            instr_ack_d = 1'b1;
            rd_instr_d  = data_in_BUS;
          end
        end else if (wait_expired) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= SRC_DATA;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rd_cpu_q    <= '0;
      rd_instr_q  <= '0;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      data_ack_q  <= 1'b0;
      instr_ack_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rd_cpu_q    <= rd_cpu_d;
      rd_instr_q  <= rd_instr_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      data_ack_q  <= data_ack_d;
      instr_ack_q <= instr_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign state          = state_q;
  assign address_out    = addr_q;
  assign data_out_BUS   = wdata_q;
  assign sel_out        = sel_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign data_out_CPU   = rd_cpu_q;
  assign data_out_INSTR = rd_instr_q;
  assign data_ack       = data_ack_q;
  assign instr_ack      = instr_ack_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_memcontrol_arb.sv
// Directed-vector bench for memcontrol_arb: a default-timeout instance and a TIMEOUT=4 instance.
module tb_memcontrol_arb;
  import memcontrol_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address_in = '0, pc_in = '0, data_in_CPU = '0, data_in_BUS = '0;
  logic [3:0]  byte_en = '0;

  logic        mem_read = 1'b0, mem_write = 1'b0, instr_en = 1'b0, bus_full = 1'b0;
  logic [31:0] a_addr, a_wdata, a_rd_cpu, a_rd_instr;
  logic [3:0]  a_sel;
  logic        a_bus_read, a_bus_write, a_data_ack, a_instr_ack, a_bus_err;
  state_t      a_state;

  logic        m2_read = 1'b0, m2_write = 1'b0, i2_en = 1'b0, bus_full2 = 1'b0;
  logic [31:0] b_addr, b_wdata, b_rd_cpu, b_rd_instr;
  logic [3:0]  b_sel;
  logic        b_bus_read, b_bus_write, b_data_ack, b_instr_ack, b_bus_err;
  state_t      b_state;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  memcontrol_arb dut (
    .clk(clk), .rst(rst), .address_in(address_in), .pc_in(pc_in),
    .data_in_CPU(data_in_CPU), .byte_en(byte_en), .memRead(mem_read),
    .memWrite(mem_write), .instr_en(instr_en), .data_in_BUS(data_in_BUS),
    .bus_full(bus_full), .address_out(a_addr), .data_out_BUS(a_wdata),
    .sel_out(a_sel), .bus_read(a_bus_read), .bus_write(a_bus_write),
    .data_out_CPU(a_rd_cpu), .data_out_INSTR(a_rd_instr), .data_ack(a_data_ack),
    .instr_ack(a_instr_ack), .bus_err(a_bus_err), .state(a_state)
  );

  memcontrol_arb #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .address_in(address_in), .pc_in(pc_in),
    .data_in_CPU(data_in_CPU), .byte_en(byte_en), .memRead(m2_read),
    .memWrite(m2_write), .instr_en(i2_en), .data_in_BUS(data_in_BUS),
    .bus_full(bus_full2), .address_out(b_addr), .data_out_BUS(b_wdata),
    .sel_out(b_sel), .bus_read(b_bus_read), .bus_write(b_bus_write),
    .data_out_CPU(b_rd_cpu), .data_out_INSTR(b_rd_instr), .data_ack(b_data_ack),
    .instr_ack(b_instr_ack), .bus_err(b_bus_err), .state(b_state)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    mem_read = 1'b1; mem_write = 1'b1; instr_en = 1'b1; m2_read = 1'b1;
    rst = 1'b1;
    step(2);
    vec_cnt++;
    if ({a_bus_read, a_bus_write, a_data_ack, a_instr_ack, a_bus_err} !== 5'b0) begin
      miss_cnt++; $display("FAIL reset_strobes: got %b want 00000",
        {a_bus_read, a_bus_write, a_data_ack, a_instr_ack, a_bus_err});
    end
    vec_cnt++;
    if ({a_addr, a_wdata, a_sel, a_rd_cpu, a_rd_instr} !== '0) begin
      miss_cnt++; $display("FAIL reset_data: addr %h wdata %h sel %b cpu %h instr %h want all 0",
        a_addr, a_wdata, a_sel, a_rd_cpu, a_rd_instr);
    end
    vec_cnt++;
    if (a_state !== IDLE || b_state !== IDLE) begin
      miss_cnt++; $display("FAIL reset_state: got %0d/%0d want IDLE", a_state, b_state);
    end
    mem_read = 1'b0; mem_write = 1'b0; instr_en = 1'b0; m2_read = 1'b0;
    rst = 1'b0;
    step(1);
    vec_cnt++;
    if (a_state !== IDLE || a_bus_read !== 1'b0) begin
      miss_cnt++; $display("FAIL reset_release: state %0d rd %b want IDLE 0", a_state, a_bus_read);
    end
  endtask

  task automatic test_fetch;
    pc_in = 32'h0000_0040; data_in_BUS = 32'h0000_0013; bus_full = 1'b0;
    instr_en = 1'b1;
    step(1);
    vec_cnt++;
    if (a_state !== FETCH_REQ || a_bus_read !== 1'b1 || a_bus_write !== 1'b0 || a_addr !== 32'h40) begin
      miss_cnt++; $display("FAIL fetch_req: state %0d rd %b wr %b addr %h want FETCH_REQ 1 0 40",
        a_state, a_bus_read, a_bus_write, a_addr);
    end
    step(1);
    vec_cnt++;
    if (a_state !== WAIT || a_bus_read !== 1'b0 || a_addr !== 32'h40) begin
      miss_cnt++; $display("FAIL fetch_wait: state %0d rd %b addr %h want WAIT 0 40",
        a_state, a_bus_read, a_addr);
    end
    step(1);
    vec_cnt++;
    if (a_instr_ack !== 1'b0) begin
      miss_cnt++; $display("FAIL fetch_early_ack: got %b want 0", a_instr_ack);
    end
    step(1);
    vec_cnt++;
    if (a_state !== DONE || a_instr_ack !== 1'b1 || a_data_ack !== 1'b0 || a_rd_instr !== 32'h13) begin
      miss_cnt++; $display("FAIL fetch_ack: state %0d iack %b dack %b instr %h want DONE 1 0 00000013",
        a_state, a_instr_ack, a_data_ack, a_rd_instr);
    end
    instr_en = 1'b0;
    step(1);
    vec_cnt++;
    if (a_state !== IDLE || a_instr_ack !== 1'b0 || a_rd_instr !== 32'h13) begin
      miss_cnt++; $display("FAIL fetch_after: state %0d iack %b instr %h want IDLE 0 00000013",
        a_state, a_instr_ack, a_rd_instr);
    end
  endtask

  task automatic test_contention;
    address_in = 32'h100; data_in_CPU = 32'hDEAD_BEEF; byte_en = 4'b0011;
    pc_in = 32'h40; data_in_BUS = 32'h0000_0013; bus_full = 1'b0;
    mem_read = 1'b1; mem_write = 1'b1; instr_en = 1'b1;
    step(1);
    vec_cnt++;
    if (a_state !== WRITE_REQ || a_bus_write !== 1'b1 || a_bus_read !== 1'b0) begin
      miss_cnt++; $display("FAIL contend_grant: state %0d wr %b rd %b want WRITE_REQ 1 0",
        a_state, a_bus_write, a_bus_read);
    end
    vec_cnt++;
    if (a_addr !== 32'h100 || a_sel !== 4'b0011 || a_wdata !== 32'hDEAD_BEEF) begin
      miss_cnt++; $display("FAIL contend_bus: addr %h sel %b data %h want 00000100 0011 deadbeef",
        a_addr, a_sel, a_wdata);
    end
    data_in_CPU = 32'h0; byte_en = 4'b1111;
    step(1);
    vec_cnt++;
    if (a_bus_write !== 1'b0 || a_sel !== 4'b0011 || a_wdata !== 32'hDEAD_BEEF) begin
      miss_cnt++; $display("FAIL contend_hold: wr %b sel %b data %h want 0 0011 deadbeef",
        a_bus_write, a_sel, a_wdata);
    end
    step(2);
    vec_cnt++;
    if (a_data_ack !== 1'b1 || a_instr_ack !== 1'b0 || a_rd_cpu !== 32'h0) begin
      miss_cnt++; $display("FAIL contend_wack: dack %b iack %b cpu %h want 1 0 00000000",
        a_data_ack, a_instr_ack, a_rd_cpu);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    data_in_BUS = 32'h0000_0093;
    step(2);
    vec_cnt++;
    if (a_state !== FETCH_REQ || a_bus_read !== 1'b1 || a_addr !== 32'h40 || a_sel !== 4'b1111) begin
      miss_cnt++; $display("FAIL contend_fetch: state %0d rd %b addr %h sel %b want FETCH_REQ 1 40 1111",
        a_state, a_bus_read, a_addr, a_sel);
    end
    step(3);
    vec_cnt++;
    if (a_instr_ack !== 1'b1 || a_rd_instr !== 32'h93 || a_rd_cpu !== 32'h0) begin
      miss_cnt++; $display("FAIL contend_fack: iack %b instr %h cpu %h want 1 00000093 00000000",
        a_instr_ack, a_rd_instr, a_rd_cpu);
    end
    instr_en = 1'b0;
    step(2);
  endtask

  task automatic test_stall;
    address_in = 32'h200; data_in_BUS = 32'h0000_1234; bus_full = 1'b1;
    mem_read = 1'b1;
    step(1);
    mem_read = 1'b0;
    step(6);
    vec_cnt++;
    if (a_state !== WAIT || a_data_ack !== 1'b0) begin
      miss_cnt++; $display("FAIL stall_busy: state %0d dack %b want WAIT 0", a_state, a_data_ack);
    end
    bus_full = 1'b0;
    step(1);
    vec_cnt++;
    if (a_data_ack !== 1'b1 || a_rd_cpu !== 32'h1234 || a_rd_instr !== 32'h93) begin
      miss_cnt++; $display("FAIL stall_ack: dack %b cpu %h instr %h want 1 00001234 00000093",
        a_data_ack, a_rd_cpu, a_rd_instr);
    end
    step(1);
    vec_cnt++;
    if (a_state !== IDLE || a_data_ack !== 1'b0) begin
      miss_cnt++; $display("FAIL stall_after: state %0d dack %b want IDLE 0", a_state, a_data_ack);
    end
  endtask

  task automatic test_timeout;
    address_in = 32'h300; data_in_BUS = 32'h5555_AAAA; bus_full2 = 1'b0;
    m2_read = 1'b1;
    step(4);
    vec_cnt++;
    if (b_data_ack !== 1'b1 || b_rd_cpu !== 32'h5555_AAAA) begin
      miss_cnt++; $display("FAIL to_preload: dack %b cpu %h want 1 5555aaaa", b_data_ack, b_rd_cpu);
    end
    m2_read = 1'b0;
    step(1);
    data_in_BUS = 32'hBAD0_BAD0; bus_full2 = 1'b1;
    m2_read = 1'b1;
    step(1);
    m2_read = 1'b0;
    step(5);
    vec_cnt++;
    if (b_state !== WAIT || b_bus_err !== 1'b0) begin
      miss_cnt++; $display("FAIL to_pending: state %0d err %b want WAIT 0", b_state, b_bus_err);
    end
    step(1);
    vec_cnt++;
    if (b_bus_err !== 1'b1 || b_state !== IDLE || b_data_ack !== 1'b0 || b_rd_cpu !== 32'h5555_AAAA) begin
      miss_cnt++; $display("FAIL to_abort: err %b state %0d dack %b cpu %h want 1 IDLE 0 5555aaaa",
        b_bus_err, b_state, b_data_ack, b_rd_cpu);
    end
    step(1);
    vec_cnt++;
    if (b_bus_err !== 1'b0 || b_data_ack !== 1'b0 || b_state !== IDLE) begin
      miss_cnt++; $display("FAIL to_after: err %b dack %b state %0d want 0 0 IDLE",
        b_bus_err, b_data_ack, b_state);
    end
    bus_full2 = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid_wait;
    address_in = 32'h400; bus_full = 1'b1;
    mem_read = 1'b1;
    step(3);
    vec_cnt++;
    if (a_state !== WAIT) begin
      miss_cnt++; $display("FAIL rmw_wait: state %0d want WAIT", a_state);
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (a_state !== IDLE || a_bus_read !== 1'b0 || a_bus_write !== 1'b0 || a_addr !== 32'h0) begin
      miss_cnt++; $display("FAIL rmw_async: state %0d rd %b wr %b addr %h want IDLE 0 0 0",
        a_state, a_bus_read, a_bus_write, a_addr);
    end
    step(1);
    mem_read = 1'b0; bus_full = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      vec_cnt++;
      if (a_data_ack !== 1'b0 || a_instr_ack !== 1'b0 || a_bus_err !== 1'b0 || a_state !== IDLE) begin
        miss_cnt++; $display("FAIL rmw_quiet[%0d]: dack %b iack %b err %b state %0d want 0 0 0 IDLE",
          i, a_data_ack, a_instr_ack, a_bus_err, a_state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_stall();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/memcontrol_arb.md
# memcontrol_arb

Parametrised memory controller between the RV32I core and the external bus. It arbitrates a data port (load/store, with byte enables) and an instruction-fetch port onto a single bus master interface. It runs a request/wait/complete handshake against `bus_full`, returns read data to the requesting port with a one-cycle acknowledge, and aborts with an error flag if the bus stalls beyond a programmable timeout. It replaces the fixed 32-bit single-channel controller.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `TIMEOUT`, 255: maximum WAIT cycles before abort; range 1 to 2^16-1.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `address_in` in ADDR_W: data-port address.
- `pc_in` in ADDR_W: instruction-fetch address.
- `data_in_CPU` in DATA_W: store data.
- `byte_en` in DATA_W/8: store byte enables.
- `memRead` in 1: data-port read request, level.
- `memWrite` in 1: data-port write request, level.
- `instr_en` in 1: fetch request, level.
- `data_in_BUS` in DATA_W: bus read data.
- `bus_full` in 1: bus busy.
- `address_out` out ADDR_W: bus address.
- `data_out_BUS` out DATA_W: bus write data.
- `sel_out` out DATA_W/8: bus byte select.
- `bus_read` out 1: read strobe.
- `bus_write` out 1: write strobe.
- `data_out_CPU` out DATA_W: load data, registered.
- `data_out_INSTR` out DATA_W: fetched instruction, registered.
- `data_ack` out 1: data-port completion pulse.
- `instr_ack` out 1: fetch completion pulse.
- `bus_err` out 1: timeout pulse.
- `state` out state_t: current FSM state, for debug.

## Operation
- States: IDLE, READ_REQ, WRITE_REQ, FETCH_REQ, WAIT, DONE.
- IDLE arbitration uses fixed priority: memWrite > memRead > instr_en.
  - memWrite and memRead both high: treated as a write; the read request is ignored.
- On grant, latch the address, store data, byte_en (all-ones for reads), and the source (DATA or INSTR). The latched values drive the bus for the whole transaction.
- *_REQ: lasts exactly 1 cycle.
  - Asserts bus_read (READ/FETCH) or bus_write (WRITE), with address_out, data_out_BUS and sel_out valid.
  - Always goes to WAIT next.
- WAIT: strobes are low; address, data and select stay held.
  - wait_cnt starts at 0 and increments every cycle.
  - Completion: wait_cnt ≥ 1 and bus_full == 0. The first WAIT cycle never completes, which gives a minimum bus latency of 2 cycles.
  - On completion, capture data_in_BUS into data_out_CPU (DATA read) or data_out_INSTR (FETCH), then go to DONE.
  - Writes capture nothing.
  - Timeout: wait_cnt == TIMEOUT with bus_full still 1. Go to IDLE, pulse bus_err for 1 cycle, issue no ack, and leave the data registers unchanged.
  - Completion and timeout in the same cycle: completion wins.
- DONE: pulse data_ack or instr_ack for 1 cycle, then go to IDLE.
  - A new request cannot be granted until the cycle after DONE, so back-to-back transactions take REQ + WAIT(n) + DONE + IDLE.
- Requests are sampled only in IDLE. Changes to requests or inputs mid-transaction are ignored.
- Requesters must drop their request on the ack cycle, or it is re-granted.

## Timing
- Reset (asynchronous): state = IDLE; every output is 0; wait_cnt and all latched fields are 0.
- Reset asserted mid-transaction: the transaction is abandoned immediately, with no ack and no err. Strobes go low asynchronously.
- Fastest read: request seen in IDLE at edge 0 → REQ at edge 1 → WAIT at edge 2 → completes at edge 3 if bus_full = 0 → DONE (ack high, data valid) at edge 4.
  - Request-to-ack latency is 4 cycles, plus 1 per extra busy WAIT cycle.
- data_out_CPU and data_out_INSTR hold their value until the next successful read of the same source.
- sel_out and data_out_BUS are meaningful only while bus_write is high or during a write WAIT.
- wait_cnt width is $clog2(TIMEOUT+1); it never wraps.

## Structure
- Package `memcontrol_pkg`:
  - state_t enum (3 bits).
  - src_t enum {SRC_DATA, SRC_INSTR}.
  - Default width constants.
- Sub-module `mem_wait_timer`:
  - Parametrised by TIMEOUT.
  - Inputs: clr, en. Outputs: first (wait_cnt == 0), expired.
  - Cleared on REQ, enabled in WAIT.
- The FSM, arbitration and data latches live in the top module.

## Test plan
- Power-on reset: assert rst for 2 cycles with all requests high → state IDLE, all outputs 0, no strobe.
- Fetch: instr_en = 1, pc_in = 0x0000_0040, bus_full = 0, data_in_BUS = 0x0000_0013 → bus_read pulses with address_out = 0x40; 4 cycles after the request, instr_ack = 1 and data_out_INSTR = 0x13.
- Contention: memRead, memWrite and instr_en all high, address_in = 0x100, data_in_CPU = 0xDEADBEEF, byte_en = 4'b0011 → bus_write first, with sel_out = 0011 and data_out_BUS = 0xDEADBEEF; the fetch is served only after data_ack and the requests drop.
- Stall: read with bus_full high for 5 WAIT cycles, then low, data_in_BUS = 0x1234 → data_ack 8 cycles after the request, data_out_CPU = 0x1234.
- Timeout: TIMEOUT = 4, bus_full stuck at 1 → bus_err pulses once after 4 WAIT cycles, no ack, returns to IDLE, data_out_CPU unchanged.
- Reset mid-WAIT: rst asserted during WAIT → IDLE immediately, strobes 0, no ack after release.
